// File: rtl/tri_pkg.sv
// Shared definitions for the triangle animator and the point-in-triangle tester.
package tri_pkg;

    localparam int COORD_W       = 12;
    localparam int VEL_W         = 4;
    localparam int BOUND_W       = COORD_W + 1;
    localparam int SCREEN_W_DFLT = 1220;
    localparam int SCREEN_H_DFLT = 480;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [VEL_W-1:0] vel_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CHECK,
        COMMIT
    } anim_state_t;

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Modular add of a signed velocity; callers guarantee the result stays on screen.
    function automatic coord_t coord_add(input coord_t c, input vel_t v);
        return c + {{(COORD_W-VEL_W){v[VEL_W-1]}}, v};
    endfunction

endpackage

// File: rtl/triangle_animator_if.sv
// Frame strobe / enable in, triangle vertices and update strobe out.
interface triangle_animator_if;
    import tri_pkg::*;

    logic   frame_start;
    logic   run;
    coord_t Ponto1X, Ponto1Y;
    coord_t Ponto2X, Ponto2Y;
    coord_t Ponto3X, Ponto3Y;
    logic   upd;

    modport master (
        input  frame_start, run,
        output Ponto1X, Ponto1Y, Ponto2X, Ponto2Y, Ponto3X, Ponto3Y, upd
    );

    modport slave (
        output frame_start, run,
        input  Ponto1X, Ponto1Y, Ponto2X, Ponto2Y, Ponto3X, Ponto3Y, upd
    );

endinterface

// File: rtl/tri_bbox.sv
// Combinational bounding box of three vertices.
module tri_bbox
    import tri_pkg::*;
(
    input  coord_t x1,
    input  coord_t x2,
    input  coord_t x3,
    input  coord_t y1,
    input  coord_t y2,
    input  coord_t y3,
    output coord_t min_x,
    output coord_t max_x,
    output coord_t min_y,
    output coord_t max_y
);

    // Pairwise compare, then fold in the third vertex.
    always_comb begin
        min_x = (x1 < x2) ? x1 : x2;
        if (x3 < min_x) min_x = x3;
        max_x = (x1 > x2) ? x1 : x2;
        if (x3 > max_x) max_x = x3;
        min_y = (y1 < y2) ? y1 : y2;
        if (y3 < min_y) min_y = y3;
        max_y = (y1 > y2) ? y1 : y2;
        if (y3 > max_y) max_y = y3;
    end

endmodule

// File: rtl/triangle_animator.sv
// Moves the triangle by its velocity once every FRAME_DIV frames during
// vertical blanking, bouncing off the screen edges.
//   state  | meaning
//   IDLE   | waiting for frame_start, counting frames
//   CALC   | latch bounding box of current vertices
//   CHECK  | reflect velocity on any axis that would leave the screen
//   COMMIT | write all six coordinates in one edge, pulse upd
module triangle_animator
    import tri_pkg::*;
#(
    parameter int P1X_INIT  = 200,
    parameter int P1Y_INIT  = 100,
    parameter int P2X_INIT  = 500,
    parameter int P2Y_INIT  = 300,
    parameter int P3X_INIT  = 500,
    parameter int P3Y_INIT  = 100,
    parameter int DX        = 2,
    parameter int DY        = 1,
    parameter int FRAME_DIV = 1,
    parameter int SCREEN_W  = SCREEN_W_DFLT,
    parameter int SCREEN_H  = SCREEN_H_DFLT
) (
    input  logic CLOCK_50,
    input  logic RST_N,
    triangle_animator_if.master bus
);

    localparam int BB_W = max3(P1X_INIT, P2X_INIT, P3X_INIT) - min3(P1X_INIT, P2X_INIT, P3X_INIT);
    localparam int BB_H = max3(P1Y_INIT, P2Y_INIT, P3Y_INIT) - min3(P1Y_INIT, P2Y_INIT, P3Y_INIT);

    // Reject parameter sets that could move the triangle off screen.
    generate
        if (DX < 1 || DX > 7 || DY < 1 || DY > 7 || FRAME_DIV < 1 || FRAME_DIV > 255 ||
            BB_W + DX >= SCREEN_W || BB_H + DY >= SCREEN_H ||
            min3(P1X_INIT, P2X_INIT, P3X_INIT) < 0 || max3(P1X_INIT, P2X_INIT, P3X_INIT) >= SCREEN_W ||
            min3(P1Y_INIT, P2Y_INIT, P3Y_INIT) < 0 || max3(P1Y_INIT, P2Y_INIT, P3Y_INIT) >= SCREEN_H)
        begin : g_bad_params
            $error("triangle_animator: parameters allow the triangle to leave the screen");
        end
    endgenerate

    localparam coord_t PX_INIT [3] = '{coord_t'(P1X_INIT), coord_t'(P2X_INIT), coord_t'(P3X_INIT)};
    localparam coord_t PY_INIT [3] = '{coord_t'(P1Y_INIT), coord_t'(P2Y_INIT), coord_t'(P3Y_INIT)};
    localparam logic signed [BOUND_W-1:0] X_LIMIT    = BOUND_W'(SCREEN_W - 1);
    localparam logic signed [BOUND_W-1:0] Y_LIMIT    = BOUND_W'(SCREEN_H - 1);
    localparam logic signed [BOUND_W-1:0] BOUND_ZERO = '0;

    anim_state_t state_q, state_d;
    logic [7:0]  cnt_q;
    logic        cnt_inc, cnt_clr, bbox_ld, check_en, commit_en;
    coord_t      px_q [3];
    coord_t      py_q [3];
    vel_t        vx_q, vy_q;
    coord_t      bb_min_x, bb_max_x, bb_min_y, bb_max_y;
    coord_t      min_x_q, max_x_q, min_y_q, max_y_q;
    logic        upd_q;
    logic signed [BOUND_W-1:0] vx_ext, vy_ext, lo_x, hi_x, lo_y, hi_y;
    logic        flip_x, flip_y;

    tri_bbox u_bbox (
        .x1    (px_q[0]),
        .x2    (px_q[1]),
        .x3    (px_q[2]),
        .y1    (py_q[0]),
        .y2    (py_q[1]),
        .y3    (py_q[2]),
        .min_x (bb_min_x),
        .max_x (bb_max_x),
        .min_y (bb_min_y),
        .max_y (bb_max_y)
    );

    assign vx_ext = BOUND_W'(vx_q);
    assign vy_ext = BOUND_W'(vy_q);
    assign lo_x   = $signed({1'b0, min_x_q}) + vx_ext;
    assign hi_x   = $signed({1'b0, max_x_q}) + vx_ext;
    assign lo_y   = $signed({1'b0, min_y_q}) + vy_ext;
    assign hi_y   = $signed({1'b0, max_y_q}) + vy_ext;
    assign flip_x = (hi_x > X_LIMIT) || (lo_x < BOUND_ZERO);
    assign flip_y = (hi_y > Y_LIMIT) || (lo_y < BOUND_ZERO);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-state strobes; frame_start only matters in IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        bbox_ld   = 1'b0;
        check_en  = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_start && bus.run) begin
                    if (cnt_q == 8'(FRAME_DIV - 1)) begin
                        cnt_clr = 1'b1;
                        state_d = CALC;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            CALC: begin
                bbox_ld = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                check_en = 1'b1;
                state_d  = COMMIT;
            end
            COMMIT: begin
                commit_en = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame divider.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N)       cnt_q <= '0;
        else if (cnt_clr) cnt_q <= '0;
        else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
    end

    // Bounding box snapshot used by the edge check.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
        end else if (bbox_ld) begin
            min_x_q <= bb_min_x;
            max_x_q <= bb_max_x;
            min_y_q <= bb_min_y;
            max_y_q <= bb_max_y;
        end
    end

    // Velocity reflection at the screen edges.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            vx_q <= vel_t'(DX);
            vy_q <= vel_t'(DY);
        end else if (check_en) begin
            if (flip_x) vx_q <= -vx_q;
            if (flip_y) vy_q <= -vy_q;
        end
    end

    // Atomic vertex update and its strobe.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 3; i++) begin
                px_q[i] <= PX_INIT[i];
                py_q[i] <= PY_INIT[i];
            end
            upd_q <= 1'b0;
        end else begin
            upd_q <= commit_en;
            if (commit_en) begin
                for (int i = 0; i < 3; i++) begin
                    px_q[i] <= coord_add(px_q[i], vx_q);
                    py_q[i] <= coord_add(py_q[i], vy_q);
                end
            end
        end
    end

    assign bus.Ponto1X = px_q[0];
    assign bus.Ponto1Y = py_q[0];
    assign bus.Ponto2X = px_q[1];
    assign bus.Ponto2Y = py_q[1];
    assign bus.Ponto3X = px_q[2];
    assign bus.Ponto3Y = py_q[2];
    assign bus.upd     = upd_q;

endmodule

// File: tb/tb_triangle_animator.sv
// Bench for triangle_animator: four parameterisations share one stimulus stream,
// each tracked every cycle by a frame-level reference model.
module tb_triangle_animator;
    import tri_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic RST_N    = 1'b0;
    logic frame_start = 1'b0;
    logic run         = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    triangle_animator_if bus_def ();
    triangle_animator_if bus_div ();
    triangle_animator_if bus_bx ();
    triangle_animator_if bus_bxy ();

    assign bus_def.frame_start = frame_start;
    assign bus_def.run         = run;
    assign bus_div.frame_start = frame_start;
    assign bus_div.run         = run;
    assign bus_bx.frame_start  = frame_start;
    assign bus_bx.run          = run;
    assign bus_bxy.frame_start = frame_start;
    assign bus_bxy.run         = run;

    triangle_animator u_def (.CLOCK_50(CLOCK_50), .RST_N(RST_N), .bus(bus_def));
    triangle_animator #(.FRAME_DIV(3)) u_div (.CLOCK_50(CLOCK_50), .RST_N(RST_N), .bus(bus_div));
    triangle_animator #(.P2X_INIT(1218), .P3X_INIT(1218))
        u_bx (.CLOCK_50(CLOCK_50), .RST_N(RST_N), .bus(bus_bx));
    triangle_animator #(.P2X_INIT(1218), .P3X_INIT(1218), .P2Y_INIT(479))
        u_bxy (.CLOCK_50(CLOCK_50), .RST_N(RST_N), .bus(bus_bxy));

    // ---------------- reference model ----------------
    localparam int IX [4][3] = '{'{200, 500, 500}, '{200, 500, 500}, '{200, 1218, 1218}, '{200, 1218, 1218}};
    localparam int IY [4][3] = '{'{100, 300, 100}, '{100, 300, 100}, '{100, 300, 100}, '{100, 479, 100}};
    localparam int IDIV [4]  = '{1, 3, 1, 1};
    localparam int W = 1220;
    localparam int H = 480;

    int mx [4][3];
    int my [4][3];
    int mvx [4], mvy [4], mcnt [4], mpend [4];
    bit mupd [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                mx[i][j] = IX[i][j];
                my[i][j] = IY[i][j];
            end
            mvx[i] = 2;  mvy[i] = 1;
            mcnt[i] = 0; mpend[i] = 0; mupd[i] = 0;
        end
    endtask

    // One movement step: reflect on any axis whose extent would leave the screen, then translate.
    task automatic model_move(input int i);
        int lo_x, hi_x, lo_y, hi_y;
        lo_x = mx[i][0]; hi_x = mx[i][0]; lo_y = my[i][0]; hi_y = my[i][0];
        for (int j = 1; j < 3; j++) begin
            if (mx[i][j] < lo_x) lo_x = mx[i][j];
            if (mx[i][j] > hi_x) hi_x = mx[i][j];
            if (my[i][j] < lo_y) lo_y = my[i][j];
            if (my[i][j] > hi_y) hi_y = my[i][j];
        end
        if (hi_x + mvx[i] > W - 1 || lo_x + mvx[i] < 0) mvx[i] = -mvx[i];
        if (hi_y + mvy[i] > H - 1 || lo_y + mvy[i] < 0) mvy[i] = -mvy[i];
        for (int j = 0; j < 3; j++) begin
            mx[i][j] += mvx[i];
            my[i][j] += mvy[i];
        end
    endtask

    // Accepted request -> new vertices three edges later; requests during that window are dropped.
    task automatic model_step(input int i);
        mupd[i] = 0;
        if (mpend[i] > 0) begin
            mpend[i]--;
            if (mpend[i] == 0) begin
                model_move(i);
                mupd[i] = 1;
            end
        end else if (frame_start && run) begin
            if (mcnt[i] == IDIV[i] - 1) begin
                mcnt[i]  = 0;
                mpend[i] = 3;
            end else begin
                mcnt[i]++;
            end
        end
    endtask

    always @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) model_reset();
        else for (int i = 0; i < 4; i++) model_step(i);
    end

    // ---------------- checking helpers ----------------
    function automatic logic [72:0] pack7(input int a, input int b, input int c, input int d,
                                          input int e, input int f, input bit u);
        return {12'(a), 12'(b), 12'(c), 12'(d), 12'(e), 12'(f), u};
    endfunction

    function automatic logic [72:0] act_vec(input int i);
        case (i)
            0: return {bus_def.Ponto1X, bus_def.Ponto1Y, bus_def.Ponto2X, bus_def.Ponto2Y,
                       bus_def.Ponto3X, bus_def.Ponto3Y, bus_def.upd};
            1: return {bus_div.Ponto1X, bus_div.Ponto1Y, bus_div.Ponto2X, bus_div.Ponto2Y,
                       bus_div.Ponto3X, bus_div.Ponto3Y, bus_div.upd};
            2: return {bus_bx.Ponto1X, bus_bx.Ponto1Y, bus_bx.Ponto2X, bus_bx.Ponto2Y,
                       bus_bx.Ponto3X, bus_bx.Ponto3Y, bus_bx.upd};
            default: return {bus_bxy.Ponto1X, bus_bxy.Ponto1Y, bus_bxy.Ponto2X, bus_bxy.Ponto2Y,
                             bus_bxy.Ponto3X, bus_bxy.Ponto3Y, bus_bxy.upd};
        endcase
    endfunction

    function automatic logic [72:0] exp_vec(input int i);
        return pack7(mx[i][0], my[i][0], mx[i][1], my[i][1], mx[i][2], my[i][2], mupd[i]);
    endfunction

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got p1=(%0d,%0d) p2=(%0d,%0d) p3=(%0d,%0d) upd=%0b, expected p1=(%0d,%0d) p2=(%0d,%0d) p3=(%0d,%0d) upd=%0b",
                     name, act[72:61], act[60:49], act[48:37], act[36:25], act[24:13], act[12:1], act[0],
                     exp[72:61], exp[60:49], exp[48:37], exp[36:25], exp[24:13], exp[12:1], exp[0]);
        end
    endtask

    // Every cycle, every instance against the model.
    always @(posedge CLOCK_50) begin
        #3;
        for (int i = 0; i < 4; i++) check($sformatf("model_u%0d", i), act_vec(i), exp_vec(i));
    end

    task automatic do_reset();
        RST_N = 1'b0;
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic pulse_and_wait();
        frame_start = 1'b1;
        @(negedge CLOCK_50);
        frame_start = 1'b0;
        repeat (4) @(negedge CLOCK_50);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rst_n;
        bit fs;
        bit run;
        int pos;   // 0 = initial, 1 = one step, 2 = two steps
        bit upd;
    } vec_t;

    localparam int CRD [3][6] = '{'{200, 100, 500, 300, 500, 100},
                                   '{202, 101, 502, 301, 502, 101},
                                   '{204, 102, 504, 302, 504, 102}};

    vec_t tbl [20];

    initial begin
        logic [72:0] v_init, v_a;
        tbl[0]  = '{0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0};   // accepted
        tbl[3]  = '{1, 1, 1, 0, 0};   // ignored (CALC)
        tbl[4]  = '{1, 1, 1, 0, 0};   // ignored (CHECK)
        tbl[5]  = '{1, 0, 1, 1, 1};   // commit edge
        tbl[6]  = '{1, 0, 1, 1, 0};
        tbl[7]  = '{1, 0, 1, 1, 0};
        tbl[8]  = '{1, 1, 1, 1, 0};
        tbl[9]  = '{1, 0, 1, 1, 0};
        tbl[10] = '{1, 0, 1, 1, 0};
        tbl[11] = '{1, 0, 1, 2, 1};
        tbl[12] = '{1, 0, 1, 2, 0};
        tbl[13] = '{1, 1, 0, 2, 0};   // run low: no step
        tbl[14] = '{1, 0, 0, 2, 0};
        tbl[15] = '{1, 1, 0, 2, 0};
        tbl[16] = '{1, 0, 1, 2, 0};
        tbl[17] = '{1, 1, 1, 2, 0};   // accepted, reset will hit during COMMIT
        tbl[18] = '{1, 0, 1, 2, 0};
        tbl[19] = '{1, 0, 1, 2, 0};

        v_init = pack7(200, 100, 500, 300, 500, 100, 1'b0);
        v_a    = pack7(202, 101, 502, 301, 502, 101, 1'b0);

        @(negedge CLOCK_50);
        for (int r = 0; r < 20; r++) begin
            RST_N       = tbl[r].rst_n;
            frame_start = tbl[r].fs;
            run         = tbl[r].run;
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            check($sformatf("table_row%0d", r), act_vec(0),
                  pack7(CRD[tbl[r].pos][0], CRD[tbl[r].pos][1], CRD[tbl[r].pos][2],
                        CRD[tbl[r].pos][3], CRD[tbl[r].pos][4], CRD[tbl[r].pos][5], tbl[r].upd));
        end

        // Reset lands between the last CHECK edge and the COMMIT edge.
        frame_start = 1'b0;
        RST_N = 1'b0;
        #1 check("reset_mid_commit_immediate", act_vec(0), v_init);
        @(posedge CLOCK_50);
        #1 check("reset_mid_commit_no_upd", act_vec(0), v_init);
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLOCK_50);
            check("after_reset_quiet", act_vec(0), v_init);
        end
        pulse_and_wait();
        check("after_reset_step", act_vec(0), v_a);

        // Frame divider of three, with run-low pulses in between.
        do_reset();
        pulse_and_wait();
        check("div_pulse1", act_vec(1), v_init);
        run = 1'b0;
        pulse_and_wait();
        pulse_and_wait();
        run = 1'b1;
        check("div_run_low", act_vec(1), v_init);
        pulse_and_wait();
        check("div_pulse2", act_vec(1), v_init);
        pulse_and_wait();
        check("div_pulse3", act_vec(1), v_a);

        // Edge reflection on X only, then on X and Y together.
        do_reset();
        pulse_and_wait();
        check("bounce_x", act_vec(2), pack7(198, 101, 1216, 301, 1216, 101, 1'b0));
        check("bounce_xy", act_vec(3), pack7(198, 99, 1216, 478, 1216, 99, 1'b0));
        pulse_and_wait();
        check("bounce_x_step2", act_vec(2), pack7(196, 102, 1214, 302, 1214, 102, 1'b0));
        check("bounce_xy_step2", act_vec(3), pack7(196, 98, 1214, 477, 1214, 98, 1'b0));

        // Random traffic, followed cycle by cycle against the model.
        for (int n = 0; n < 5000; n++) begin
            @(negedge CLOCK_50);
            frame_start = ($urandom_range(0, 2) == 0);
            run         = ($urandom_range(0, 7) != 0);
            RST_N       = ($urandom_range(0, 1999) != 0);
        end
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        frame_start = 1'b0;
        repeat (6) @(negedge CLOCK_50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
